bird_physics: RTL and testbench
===============================

BIRD_PHYSICS -- requirements
Module: bird_physics

Interface
Parameters:
REQ-001 SHALL have parameter SCREEN_H, default 768: playfield height in px.
REQ-002 SHALL have parameter BIRD_H, default 50: sprite height in px.
REQ-003 SHALL have parameter START_Y, default 300: spawn Y of sprite top edge.
REQ-004 SHALL have parameter GRAVITY, default 1: velocity increment per tick, px/tick².
REQ-005 SHALL have parameter JUMP_VEL, default -17: velocity loaded on jump, px/tick, signed.
REQ-006 SHALL have parameter MAX_FALL_VEL, default 12: positive velocity ceiling (terminal velocity).
REQ-007 SHALL have parameter TICK_DIV, default 900_000: clk cycles per physics tick, at least 2.
REQ-008 SHALL have parameters Y_W, default 11, and V_W, default 8: position and velocity widths.

Ports:
REQ-009 SHALL have port clk, input, 1 bit: single system clock, all logic on rising edge.
REQ-010 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-011 SHALL have port game_rst, input, 1 bit: synchronous, active-high new-game restart, identical effect to rst.
REQ-012 SHALL have port jump, input, 1 bit: one-cycle click pulse.
REQ-013 SHALL have port pause, input, 1 bit: level, freezes physics while high.
REQ-014 SHALL have port bird_y, output, Y_W bits, unsigned: sprite top edge.
REQ-015 SHALL have port velocity, output, V_W bits, signed: current velocity.
REQ-016 SHALL have port state, output, 2 bits: 00 IDLE, 01 FLY, 10 DEAD.
REQ-017 SHALL have port tick, output, 1 bit: one-cycle pulse on each applied physics update.
REQ-018 SHALL have port collision, output, 1 bit: latched, high in DEAD.

Function
REQ-019 SHALL implement the FSM IDLE -> FLY -> DEAD; DEAD is left only via rst or game_rst.
REQ-020 In IDLE, SHALL hold bird_y=START_Y, velocity=0 and tick counter=0, and SHALL ignore pause.
REQ-021 In IDLE with jump=1, SHALL in the next cycle enter FLY with velocity=JUMP_VEL, counter=0 and no pending jump.
REQ-022 In FLY with pause=0, SHALL increment the counter each cycle; when counter=TICK_DIV-1, counter wraps to 0, tick=1 for that cycle, and the physics update applies.
REQ-023 In FLY with pause=1, SHALL hold counter, bird_y and velocity, keep tick=0, and drop jump pulses.
REQ-024 In FLY, a jump pulse SHALL set a pending flag; multiple pulses between ticks SHALL collapse to one.
REQ-025 A jump pulse in the same cycle as a tick SHALL count as pending for that tick.
REQ-026 Physics update, position: new_y = bird_y + velocity, using pre-update velocity, computed signed in Y_W+2 bits with no wrap.
REQ-027 Physics update, velocity: if jump is pending, velocity=JUMP_VEL and the pending flag clears; else velocity=min(velocity+GRAVITY, MAX_FALL_VEL).
REQ-028 If new_y <= 0: bird_y=0, collision=1, state=DEAD, velocity=0.
REQ-029 Else if new_y >= SCREEN_H-BIRD_H: bird_y=SCREEN_H-BIRD_H, collision=1, state=DEAD, velocity=0.
REQ-030 Otherwise: bird_y=new_y and collision stays 0.
REQ-031 In DEAD, SHALL hold bird_y, velocity=0, collision=1 and tick=0, and SHALL ignore jump and pause.
REQ-032 All outputs SHALL be registered; an update is visible the cycle after the tick cycle, and tick is asserted in the tick cycle itself.

Reset
REQ-033 On rst or game_rst, SHALL set in the next cycle: state=IDLE, bird_y=START_Y, velocity=0, collision=0, tick=0, counter=0, pending=0.
REQ-034 Reset SHALL take priority over every other input, including mid-flight and in the same cycle as a tick or jump.

Verification (use TICK_DIV=4 with other parameters at default unless stated)
REQ-035 Reset: assert rst for 1 cycle -> state=00, bird_y=300, velocity=0, collision=0, tick=0.
REQ-036 Start and first tick: jump in IDLE -> next cycle state=01, velocity=-17; 4 cycles later tick=1, then bird_y=283 and velocity=-16.
REQ-037 Terminal velocity: jump once, then no input -> velocity climbs -16 -> ... -> 12 and stays at 12 on later ticks until collision.
REQ-038 Ceiling: START_Y=10, jump -> first tick new_y=-7 -> bird_y=0, collision=1, state=10; later jumps are ignored.
REQ-039 Pause and floor: pause=1 for 10 cycles mid-flight -> bird_y, velocity and counter are unchanged and tick=0; free fall to the floor -> bird_y=718, state=10.
REQ-040 game_rst mid-flight, coinciding with a tick and a jump -> next cycle state=00, bird_y=300, velocity=0, no tick effect.

Source files
------------

// File: rtl/bird_physics.sv
// Vertical physics for a flappy-style sprite: gravity, jump impulse,
// terminal velocity and ceiling/floor collision, advanced on a divided tick.
module bird_physics #(
  parameter int SCREEN_H     = 768,
  parameter int BIRD_H       = 50,
  parameter int START_Y      = 300,
  parameter int GRAVITY      = 1,
  parameter int JUMP_VEL     = -17,
  parameter int MAX_FALL_VEL = 12,
  parameter int TICK_DIV     = 900_000,
  parameter int Y_W          = 11,
  parameter int V_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  game_rst,
  input  logic                  jump,
  input  logic                  pause,
  output logic [Y_W-1:0]        bird_y,
  output logic signed [V_W-1:0] velocity,
  output logic [1:0]            state,
  output logic                  tick,
  output logic                  collision
);

  typedef enum logic [1:0] {IDLE = 2'b00, FLY = 2'b01, DEAD = 2'b10} state_e;

  localparam int CW    = $clog2(TICK_DIV);
  localparam int FLOOR = SCREEN_H - BIRD_H;
  localparam logic signed [V_W-1:0] JV   = V_W'(JUMP_VEL);
  localparam logic signed [V_W-1:0] VMAX = V_W'(MAX_FALL_VEL);

  state_e                state_q, state_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic signed [V_W-1:0] v_q, v_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  coll_q, coll_d;

  logic                  tick_w, pend_w, hit_top, hit_bot;
  logic signed [Y_W+1:0] new_y;
  logic signed [V_W:0]   v_grav;

  assign tick_w  = (state_q == FLY) && !pause && (cnt_q == CW'(TICK_DIV - 1));
  assign pend_w  = pend_q | jump;
  // Two guard bits keep the sum from wrapping past either screen edge.
  assign new_y   = $signed({2'b00, y_q}) + $signed({{(Y_W+2-V_W){v_q[V_W-1]}}, v_q});
  assign v_grav  = $signed({v_q[V_W-1], v_q}) + $signed((V_W+1)'(GRAVITY));
  assign hit_top = (new_y <= 0);
  assign hit_bot = (new_y >= FLOOR);

  always_ff @(posedge clk) begin
    if (rst || game_rst) begin
      state_q <= IDLE;
      y_q     <= Y_W'(START_Y);
      v_q     <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      coll_q  <= coll_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (jump) state_d = FLY;
      FLY:     if (tick_w && (hit_top || hit_bot)) state_d = DEAD;
      DEAD:    state_d = DEAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    y_d    = y_q;
    v_d    = v_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    coll_d = coll_q;
    case (state_q)
      IDLE: begin
        y_d    = Y_W'(START_Y);
        v_d    = jump ? JV : '0;
        cnt_d  = '0;
        pend_d = 1'b0;
        coll_d = 1'b0;
      end
      FLY: if (!pause) begin
        cnt_d  = tick_w ? '0 : cnt_q + CW'(1);
        pend_d = pend_w;
        if (tick_w) begin
          pend_d = 1'b0;
          v_d    = pend_w ? JV : ((v_grav > $signed({VMAX[V_W-1], VMAX})) ? VMAX : v_grav[V_W-1:0]);
          if (hit_top) begin
            y_d    = '0;
            v_d    = '0;
            coll_d = 1'b1;
          end else if (hit_bot) begin
            y_d    = Y_W'(FLOOR);
            v_d    = '0;
            coll_d = 1'b1;
          end else begin
            y_d    = new_y[Y_W-1:0];
          end
        end
      end
      DEAD: begin
        v_d    = '0;
        coll_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bird_y    = y_q;
  assign velocity  = v_q;
  assign state     = state_q;
  assign tick      = tick_w;
  assign collision = coll_q;

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics at TICK_DIV=4: start, ticks, jump collapse,
// pause, terminal velocity, floor/ceiling death and restart priority.
module tb_bird_physics;

  logic clk = 1'b0;
  logic rst, game_rst, jump, pause, jump2;
  logic [10:0]       bird_y, bird_y2;
  logic signed [7:0] velocity, velocity2;
  logic [1:0]        state, state2;
  logic              tick, tick2, collision, collision2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bird_physics #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .game_rst(game_rst), .jump(jump), .pause(pause),
    .bird_y(bird_y), .velocity(velocity), .state(state), .tick(tick), .collision(collision)
  );

  bird_physics #(.TICK_DIV(4), .START_Y(10)) dut2 (
    .clk(clk), .rst(rst), .game_rst(1'b0), .jump(jump2), .pause(1'b0),
    .bird_y(bird_y2), .velocity(velocity2), .state(state2), .tick(tick2), .collision(collision2)
  );

  task automatic chk(input string tag, input logic signed [63:0] o, input logic signed [63:0] e);
    n_cmp++;
    if (o !== e) begin
      n_err++;
      $error("FAIL %s obs=%0d exp=%0d", tag, o, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_jump();
    jump = 1'b1; @(negedge clk); jump = 1'b0;
  endtask

  initial begin
    rst = 1'b1; game_rst = 1'b0; jump = 1'b0; pause = 1'b0; jump2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_state", state, 2'b00);
    chk("rst_y", bird_y, 11'd300);
    chk("rst_v", $signed(velocity), -8'sd0);
    chk("rst_coll", collision, 1'b0);
    chk("rst_tick", tick, 1'b0);

    // IDLE ignores pause
    pause = 1'b1; step(5); pause = 1'b0;
    chk("idle_state", state, 2'b00);
    chk("idle_y", bird_y, 11'd300);
    chk("idle_tick", tick, 1'b0);

    // start and first tick
    pulse_jump();
    chk("start_state", state, 2'b01);
    chk("start_v", $signed(velocity), -8'sd17);
    chk("start_tick", tick, 1'b0);
    step(3);
    chk("tick1_pulse", tick, 1'b1);
    chk("tick1_y_before", bird_y, 11'd300);
    step(1);
    chk("tick1_y", bird_y, 11'd283);
    chk("tick1_v", $signed(velocity), -8'sd16);
    chk("tick1_off", tick, 1'b0);

    // two pulses between ticks collapse to one jump
    pulse_jump(); step(1); pulse_jump();
    chk("tick2_pulse", tick, 1'b1);
    step(1);
    chk("collapse_y", bird_y, 11'd267);
    chk("collapse_v", $signed(velocity), -8'sd17);
    step(4);
    chk("tick3_y", bird_y, 11'd250);
    chk("tick3_v", $signed(velocity), -8'sd16);

    // jump coinciding with the tick cycle
    step(3);
    chk("tick4_pulse", tick, 1'b1);
    pulse_jump();
    chk("cotick_y", bird_y, 11'd234);
    chk("cotick_v", $signed(velocity), -8'sd17);

    // pause for 10 cycles with a dropped jump, counter at 2
    step(2);
    pause = 1'b1;
    step(3); pulse_jump(); step(2);
    chk("pause_tick", tick, 1'b0);
    step(4);
    chk("pause_tick_end", tick, 1'b0);
    pause = 1'b0;
    chk("pause_y", bird_y, 11'd234);
    chk("pause_v", $signed(velocity), -8'sd17);
    step(1);
    chk("resume_tick", tick, 1'b1);
    step(1);
    chk("resume_y", bird_y, 11'd217);
    chk("resume_v", $signed(velocity), -8'sd16);

    // free fall: velocity saturates at 12, then floor
    step(4*28);
    chk("term_v", $signed(velocity), 8'sd12);
    chk("term_y", bird_y, 11'd147);
    step(8);
    chk("term_v_hold", $signed(velocity), 8'sd12);
    chk("term_y2", bird_y, 11'd171);
    step(4*45);
    chk("prefloor_y", bird_y, 11'd711);
    chk("prefloor_state", state, 2'b01);
    chk("prefloor_coll", collision, 1'b0);
    step(4);
    chk("floor_y", bird_y, 11'd718);
    chk("floor_state", state, 2'b10);
    chk("floor_coll", collision, 1'b1);
    chk("floor_v", $signed(velocity), -8'sd0);

    // DEAD ignores jump and pause
    pulse_jump(); pause = 1'b1; step(4); pause = 1'b0; step(4);
    chk("dead_state", state, 2'b10);
    chk("dead_y", bird_y, 11'd718);
    chk("dead_tick", tick, 1'b0);

    // game_rst leaves DEAD
    game_rst = 1'b1; step(1); game_rst = 1'b0;
    chk("grst_state", state, 2'b00);
    chk("grst_coll", collision, 1'b0);
    chk("grst_y", bird_y, 11'd300);

    // game_rst coinciding with tick and jump wins
    pulse_jump(); step(3);
    chk("pre_grst_tick", tick, 1'b1);
    game_rst = 1'b1; jump = 1'b1; step(1); game_rst = 1'b0; jump = 1'b0;
    chk("grst2_state", state, 2'b00);
    chk("grst2_y", bird_y, 11'd300);
    chk("grst2_v", $signed(velocity), -8'sd0);
    chk("grst2_tick", tick, 1'b0);
    step(4);
    chk("grst2_hold_y", bird_y, 11'd300);
    pulse_jump(); step(3);
    chk("restart_tick", tick, 1'b1);

    // ceiling with START_Y=10
    jump2 = 1'b1; step(1); jump2 = 1'b0;
    chk("ceil_start_state", state2, 2'b01);
    step(3);
    chk("ceil_tick", tick2, 1'b1);
    step(1);
    chk("ceil_y", bird_y2, 11'd0);
    chk("ceil_coll", collision2, 1'b1);
    chk("ceil_state", state2, 2'b10);
    chk("ceil_v", $signed(velocity2), -8'sd0);
    jump2 = 1'b1; step(1); jump2 = 1'b0; step(8);
    chk("ceil_dead_state", state2, 2'b10);
    chk("ceil_dead_y", bird_y2, 11'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
